// File: rtl/gpu_tile_pkg.sv
// Tile geometry shared by the tile reader and tile writer, plus the reader state type.
package gpu_tile_pkg;
  localparam int TILE_ROWS      = 32;
  localparam int TILE_ROW_WORDS = 16;
  localparam int TILE_WORDS     = TILE_ROWS * TILE_ROW_WORDS;
  localparam int TILE_RAM_AW    = $clog2(TILE_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} tile_reader_state_t;
endpackage

// File: rtl/tile_reader_if.sv
// Avalon-MM read-master bus of the tile reader.
// TILE_READER_BURST_EN adds master_burstcount (one burst per tile row).
interface tile_reader_if import gpu_tile_pkg::*; ();
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_wait_request;
`ifdef TILE_READER_BURST_EN
  logic [$clog2(TILE_ROW_WORDS):0] master_burstcount;
`endif

  modport master (
    output master_address,
    output master_read,
`ifdef TILE_READER_BURST_EN
    output master_burstcount,
`endif
    input  master_readdata,
    input  master_readdatavalid,
    input  master_wait_request
  );

  modport slave (
    input  master_address,
    input  master_read,
`ifdef TILE_READER_BURST_EN
    input  master_burstcount,
`endif
    output master_readdata,
    output master_readdatavalid,
    output master_wait_request
  );
endinterface

// File: rtl/tile_read_addr_gen.sv
// Row/word request address generator: row_base accumulates the stride once per row.
// row_mode=1 advances a whole row per request (burst issue).
module tile_read_addr_gen #(
  parameter int ROWS      = 32,
  parameter int ROW_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic        row_mode,
  input  logic [31:0] base,
  input  logic [15:0] stride,
  output logic [31:0] address,
  output logic        last
);
  localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WB = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  typedef logic [RB-1:0] row_t;
  typedef logic [WB-1:0] word_t;

  row_t        row_reg;
  word_t       word_reg;
  logic [31:0] row_base_reg;
  logic [15:0] stride_reg;
  logic        row_end;

  assign row_end = row_mode || (word_reg == word_t'(ROW_WORDS - 1));
  assign last    = (row_reg == row_t'(ROWS - 1)) && row_end;
  assign address = row_base_reg + 32'({word_reg, 2'b00});

  // All address arithmetic wraps modulo 2^32 by construction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_reg      <= '0;
      word_reg     <= '0;
      row_base_reg <= '0;
      stride_reg   <= '0;
    end else if (load) begin
      row_reg      <= '0;
      word_reg     <= '0;
      row_base_reg <= base;
      stride_reg   <= stride;
    end else if (advance) begin
      if (row_end) begin
        word_reg     <= '0;
        row_reg      <= row_reg + row_t'(1);
        row_base_reg <= row_base_reg + {16'h0000, stride_reg};
      end else begin
        word_reg <= word_reg + word_t'(1);
      end
    end
  end
endmodule

// File: rtl/tile_reader.sv
// Avalon-MM read master: fetches one tile from SDRAM into tile RAM, start/busy/done handshake.
// TILE_READER_BURST_EN issues one ROW_WORDS burst per row instead of single-word reads.
module tile_reader import gpu_tile_pkg::*; #(
  parameter int ROWS        = TILE_ROWS,
  parameter int ROW_WORDS   = TILE_ROW_WORDS,
  parameter int MAX_PENDING = 8,
  parameter int RAM_AW      = TILE_RAM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       addr_in,
  input  logic [15:0]       stride_in,
  output logic              busy,
  output logic              done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              ram_wren,
  tile_reader_if.master     bus
);
  localparam int PW = $clog2(MAX_PENDING) + 1;
  typedef logic [PW-1:0]     pend_t;
  typedef logic [PW:0]       room_t;
  typedef logic [RAM_AW-1:0] idx_t;
  localparam idx_t LAST_INDEX = idx_t'(ROWS * ROW_WORDS - 1);

`ifdef TILE_READER_BURST_EN
  localparam int INC = ROW_WORDS;
  localparam logic ROW_MODE = 1'b1;
  typedef logic [$clog2(ROW_WORDS):0] burst_t;
  assign bus.master_burstcount = burst_t'(ROW_WORDS);
  if (MAX_PENDING < ROW_WORDS) begin : g_bad_pending
    $error("tile_reader: burst build needs MAX_PENDING >= ROW_WORDS");
  end
`else
  localparam int INC = 1;
  localparam logic ROW_MODE = 1'b0;
`endif
  if (RAM_AW != $clog2(ROWS * ROW_WORDS)) begin : g_bad_aw
    $error("tile_reader: RAM_AW must equal log2(ROWS*ROW_WORDS)");
  end

  tile_reader_state_t state_reg;
  pend_t              pending_reg, pending_next;
  idx_t               index_reg, ram_addr_reg;
  logic [31:0]        ram_data_reg;
  logic               busy_reg, done_reg, wren_reg;
  logic               room, accept, resp, load, last_req;
  logic [31:0]        gen_address;

  assign load   = (state_reg == IDLE) && start;
  assign room   = (room_t'(pending_reg) + room_t'(INC)) <= room_t'(MAX_PENDING);
  assign accept = bus.master_read && !bus.master_wait_request;
  // Responses with nothing outstanding are stale (e.g. after a reset) and dropped.
  assign resp   = bus.master_readdatavalid && (pending_reg != '0);

  assign bus.master_read    = (state_reg == ISSUE) && room;
  assign bus.master_address = gen_address;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign ram_wren = wren_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;

  tile_read_addr_gen #(
    .ROWS      (ROWS),
    .ROW_WORDS (ROW_WORDS)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (accept),
    .row_mode (ROW_MODE),
    .base     (addr_in),
    .stride   (stride_in),
    .address  (gen_address),
    .last     (last_req)
  );

  always_comb begin
    pending_next = pending_reg;
    if (accept) pending_next = pending_next + pend_t'(INC);
    if (resp)   pending_next = pending_next - pend_t'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      index_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      wren_reg     <= 1'b0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      wren_reg    <= resp;
      done_reg    <= 1'b0;
      if (resp) begin
        ram_addr_reg <= index_reg;
        ram_data_reg <= bus.master_readdata;
        index_reg    <= index_reg + idx_t'(1);
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= ISSUE;
            busy_reg    <= 1'b1;
            index_reg   <= '0;
            pending_reg <= '0;
          end
        end
        ISSUE: begin
          if (accept && last_req) state_reg <= DRAIN;
        end
        DRAIN: begin
          // busy drops together with done so a start on the next cycle is accepted.
          if (resp && (index_reg == LAST_INDEX)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_reader.sv
// Self-checking bench for tile_reader: table-driven transfers against an Avalon slave model.
// Build with TILE_READER_BURST_EN to exercise the burst variant (MAX_PENDING=32).
module tb_tile_reader;
  import gpu_tile_pkg::*;

`ifdef TILE_READER_BURST_EN
  localparam int MAXP = 32;
  localparam int INC  = TILE_ROW_WORDS;
  localparam int NREQ = TILE_ROWS;
`else
  localparam int MAXP = 8;
  localparam int INC  = 1;
  localparam int NREQ = TILE_WORDS;
`endif
  localparam int NW = TILE_WORDS;
  localparam int RW = TILE_ROW_WORDS;
  typedef logic [TILE_RAM_AW-1:0] idx_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] stride;
    int          waits;
    int          lat;
    int          exp_max;   // expected peak outstanding words, -1 = not checked
    bit          wrap_chk;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [31:0]            addr_in = '0;
  logic [15:0]            stride_in = '0;
  logic                   busy, done, ram_wren;
  logic [TILE_RAM_AW-1:0] ram_addr;
  logic [31:0]            ram_data;

  tile_reader_if bus ();

  tile_reader #(
    .ROWS        (TILE_ROWS),
    .ROW_WORDS   (TILE_ROW_WORDS),
    .MAX_PENDING (MAXP),
    .RAM_AW      (TILE_RAM_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr_in   (addr_in),
    .stride_in (stride_in),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  logic [31:0] cur_base = '0, cur_stride = '0, seed = '0;
  int          cfg_wait = 0, cfg_lat = 1;
  int          exp_idx = 0, wr_count = 0, done_cnt = 0, req_k = 0;
  int          tb_out = 0, max_out = 0, stall_cnt = 0, inject_cnt = 0;
  bit          prev_stalled = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] wr_data [NW];
  resp_t       rq [$];
  resp_t       r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave memory contents: a hash of the byte address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return ((a ^ seed) * 32'h9E37_79B1) ^ (a >> 7);
  endfunction

  // Address of tile word i from the row/stride geometry.
  function automatic logic [31:0] model_addr(input int i);
    return cur_base + cur_stride * 32'(i / RW) + 32'(4 * (i % RW));
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cycle++;

  // Avalon slave: programmable stall count per request and fixed response latency.
  always @(negedge clk) begin
    if (!rst) begin
      rq.delete();
      tb_out = 0;
      stall_cnt = 0;
      prev_stalled = 1'b0;
      bus.master_readdatavalid = 1'b0;
      bus.master_wait_request = 1'b0;
      bus.master_readdata = '0;
    end else begin
      chk("pending_le_max", 64'(tb_out <= MAXP), 64'd1);
      if (tb_out > max_out) max_out = tb_out;
      if (tb_out + INC > MAXP) chk("read_drop_at_max", 64'(bus.master_read), 64'd0);
      if (prev_stalled) begin
        chk("stall_read_held", 64'(bus.master_read), 64'd1);
        chk("stall_addr_held", 64'(bus.master_address), 64'(prev_addr));
      end
      if (inject_cnt > 0) begin
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata = $urandom;
        inject_cnt--;
      end else if (rq.size() > 0 && rq[0].due <= cycle + 1) begin
        r = rq.pop_front();
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata = r.data;
        tb_out--;
      end else begin
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = $urandom;
      end
      bus.master_wait_request = 1'b0;
      if (bus.master_read) begin
        if (stall_cnt < cfg_wait) begin
          bus.master_wait_request = 1'b1;
          stall_cnt++;
        end else begin
          stall_cnt = 0;
`ifdef TILE_READER_BURST_EN
          chk("req_addr", 64'(bus.master_address), 64'(cur_base + cur_stride * 32'(req_k)));
          chk("burstcount", 64'(bus.master_burstcount), 64'(RW));
          for (int j = 0; j < RW; j++)
            rq.push_back('{cycle + 1 + cfg_lat, mem(bus.master_address + 32'(4 * j))});
          tb_out += RW;
`else
          chk("req_addr", 64'(bus.master_address), 64'(model_addr(req_k)));
          rq.push_back('{cycle + 1 + cfg_lat, mem(bus.master_address)});
          tb_out++;
`endif
          req_k++;
        end
      end
      prev_stalled = bus.master_read && bus.master_wait_request;
      prev_addr = bus.master_address;
    end
  end

  // RAM write monitor: every write must carry the next index and the data of its address.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_wren) begin
        chk("ram_addr", 64'(ram_addr), 64'(exp_idx));
        chk("ram_data", 64'(ram_data), 64'(mem(model_addr(exp_idx))));
        if (exp_idx < NW) wr_data[exp_idx] = ram_data;
        exp_idx++;
        wr_count++;
      end
      if (done) begin
        done_cnt++;
        chk("done_with_last_write", 64'({ram_wren, ram_addr}), 64'({1'b1, idx_t'(NW - 1)}));
      end
    end
  end

  task automatic begin_xfer(input logic [31:0] a, input logic [15:0] s, input int w, input int l);
    cur_base = a;
    cur_stride = {16'h0000, s};
    cfg_wait = w;
    cfg_lat = l;
    exp_idx = 0;
    wr_count = 0;
    done_cnt = 0;
    req_k = 0;
    max_out = 0;
    addr_in = a;
    stride_in = s;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic run_xfer(input vec_t v);
    int  busy_drops;
    bit  got_done;
    busy_drops = 0;
    got_done = 1'b0;
    begin_xfer(v.addr, v.stride, v.waits, v.lat);
    for (int n = 0; n < 20000 && !got_done; n++) begin
      step();
      if (done) begin
        got_done = 1'b1;
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end else if (!busy) begin
        busy_drops++;
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    chk("busy_held", 64'(busy_drops), 64'd0);
    chk("ram_writes", 64'(wr_count), 64'(NW));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("requests", 64'(req_k), 64'(NREQ));
    if (v.exp_max >= 0) chk("max_outstanding", 64'(max_out), 64'(v.exp_max));
    if (v.wrap_chk) chk("wrap_row4_word0", 64'(wr_data[4 * RW]), 64'(mem(32'h0)));
    $display("xfer addr=%h stride=%h wait=%0d lat=%0d writes=%0d reqs=%0d peak=%0d",
             v.addr, v.stride, v.waits, v.lat, wr_count, req_k, max_out);
  endtask

  vec_t vecs [7];
  int   w0;

  initial begin
    vecs[0] = '{32'h0000_1000, 16'h0800, 0, 1, -1, 1'b0};
    vecs[1] = '{32'h2000_0000, 16'h0100, 3, 1, -1, 1'b0};
    vecs[2] = '{32'h0000_4000, 16'h0800, 0, 20, MAXP, 1'b0};
    vecs[3] = '{32'hFFFF_FF00, 16'h0040, 0, 2, -1, 1'b1};
    vecs[4] = '{32'h0000_8000, 16'h0000, 1, 3, -1, 1'b0};
    for (int i = 5; i < 7; i++)
      vecs[i] = '{$urandom & 32'hFFFF_FFFC, 16'($urandom) & 16'hFFFC,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), -1, 1'b0};

    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ram_wren", 64'(ram_wren), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_data", 64'(ram_data), 64'd0);
    chk("rst_master_read", 64'(bus.master_read), 64'd0);
    chk("rst_master_address", 64'(bus.master_address), 64'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      seed = $urandom;
      run_xfer(vecs[i]);
    end

    // Mid-transfer start is ignored; reset at write 100 aborts; stray responses are dropped.
    seed = $urandom;
    begin_xfer(32'h0001_0000, 16'h0400, 0, 1);
    for (int n = 0; n < 5000 && wr_count < 50; n++) step();
    addr_in = 32'hDEAD_0000;
    stride_in = 16'h0010;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_mid_transfer", 64'(busy), 64'd1);
    for (int n = 0; n < 5000 && wr_count < 100; n++) step();
    chk("reached_word_100", 64'(wr_count >= 100), 64'd1);
    rst = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ram_wren", 64'(ram_wren), 64'd0);
    chk("abort_ram_addr", 64'(ram_addr), 64'd0);
    chk("abort_ram_data", 64'(ram_data), 64'd0);
    chk("abort_master_read", 64'(bus.master_read), 64'd0);
    chk("abort_master_address", 64'(bus.master_address), 64'd0);
    rst = 1'b1;
    w0 = wr_count;
    inject_cnt = 3;
    repeat (8) step();
    chk("no_stray_writes", 64'(wr_count), 64'(w0));
    chk("idle_after_stray", 64'(busy), 64'd0);
    $display("xfer aborted at write %0d, stray responses injected", w0);

    seed = $urandom;
    run_xfer(vecs[0]);
    repeat (5) step();
    chk("no_extra_done", 64'(done_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
